// File: rtl/ysyx_23060062_adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit ripple adder among NREQ requesters.
// Optional subtract support enabled by defining YSYX_23060062_ADDER_ARB_SUB_EN.
module ysyx_23060062_adder_arbiter #(
   parameter int NREQ      = 3,
   parameter int ADDER_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
`ifdef YSYX_23060062_ADDER_ARB_SUB_EN
   input  logic [NREQ-1:0]      req_sub,
`endif
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_data,
   output logic                 rsp_cout,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   output logic                 add_cin,
   input  logic [31:0]          add_sum,
   input  logic                 add_cout,
   output logic                 busy
);

   localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int          CW = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
   localparam int unsigned NR = NREQ;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     rr_ptr, owner, gnt, rr_nxt;
   logic [CW-1:0]     cnt;
   logic              found, accept, sub_g;
   logic [31:0]       op_a [NREQ];
   logic [31:0]       op_b [NREQ];
   logic [31:0]       b_sel;
   int unsigned       idx;

   always_comb begin
      for (int unsigned i = 0; i < NR; i++) begin
         op_a[i] = req_a[32*i +: 32];
         op_b[i] = req_b[32*i +: 32];
      end
   end

   // Rotating priority: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NR; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NR) idx = idx - NR;
         if (!found && req_valid[PW'(idx)]) begin
            found = 1'b1;
            gnt   = PW'(idx);
         end
      end
   end

   assign rr_nxt = (32'(gnt) == NR - 1) ? '0 : gnt + 1'b1;
   assign accept = (state == S_IDLE) && found;

`ifdef YSYX_23060062_ADDER_ARB_SUB_EN
   assign sub_g = req_sub[gnt];
`else
   assign sub_g = 1'b0;
`endif

   // Subtraction is A + ~B + 1, so cout doubles as the not-borrow flag.
   assign b_sel = sub_g ? ~op_b[gnt] : op_b[gnt];

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      busy      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (found) begin
               req_ready[gnt] = 1'b1;
               state_nxt      = S_BUSY;
            end
         end
         S_BUSY: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = S_RESP;
         end
         S_RESP: begin
            busy             = 1'b1;
            rsp_valid[owner] = 1'b1;
            if (rsp_ready[owner]) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         cnt      <= '0;
         rsp_data <= '0;
         rsp_cout <= 1'b0;
         add_a    <= '0;
         add_b    <= '0;
         add_cin  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            add_a   <= op_a[gnt];
            add_b   <= b_sel;
            add_cin <= sub_g;
            owner   <= gnt;
            rr_ptr  <= rr_nxt;
            cnt     <= CW'(ADDER_LAT - 1);
         end
         if (state == S_BUSY) begin
            if (cnt == '0) begin
               rsp_data <= add_sum;
               rsp_cout <= add_cout;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060062_adder_arbiter.sv
// Bench for ysyx_23060062_adder_arbiter: two instances (ADDER_LAT 1 and 3) share stimulus,
// each tracked by a transaction-level model; directed literal checks pin the model.
module tb_ysyx_23060062_adder_arbiter;

   localparam int N = 3;
`ifdef YSYX_23060062_ADDER_ARB_SUB_EN
   localparam bit SUB_ON = 1'b1;
`else
   localparam bit SUB_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0]   valid = '0, rsp_rdy = '1, sub = '0;
   logic [32*N-1:0] ra = '0, rb = '0;

   logic [N-1:0] rdy0, rv0, rdy1, rv1;
   logic [31:0]  data0, data1, aa0, ab0, aa1, ab1, asum0, asum1;
   logic         cout0, cout1, acin0, acin1, acout0, acout1, bsy0, bsy1;

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  chk_en = 1'b0;

   always #5 clk = ~clk;

   assign {acout0, asum0} = {1'b0, aa0} + {1'b0, ab0} + {32'd0, acin0};
   assign {acout1, asum1} = {1'b0, aa1} + {1'b0, ab1} + {32'd0, acin1};

   ysyx_23060062_adder_arbiter #(.NREQ(N), .ADDER_LAT(1)) dut0 (
      .clk(clk), .rst(rst), .req_valid(valid), .req_ready(rdy0),
      .req_a(ra), .req_b(rb),
`ifdef YSYX_23060062_ADDER_ARB_SUB_EN
      .req_sub(sub),
`endif
      .rsp_valid(rv0), .rsp_ready(rsp_rdy), .rsp_data(data0), .rsp_cout(cout0),
      .add_a(aa0), .add_b(ab0), .add_cin(acin0), .add_sum(asum0), .add_cout(acout0),
      .busy(bsy0)
   );

   ysyx_23060062_adder_arbiter #(.NREQ(N), .ADDER_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .req_valid(valid), .req_ready(rdy1),
      .req_a(ra), .req_b(rb),
`ifdef YSYX_23060062_ADDER_ARB_SUB_EN
      .req_sub(sub),
`endif
      .rsp_valid(rv1), .rsp_ready(rsp_rdy), .rsp_data(data1), .rsp_cout(cout1),
      .add_a(aa1), .add_b(ab1), .add_cin(acin1), .add_sum(asum1), .add_cout(acout1),
      .busy(bsy1)
   );

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, d, got, exp, $time);
      end
   endtask

   // Transaction model: one outstanding operation per instance, aged in cycles since accept.
   bit          m_act [2];
   int          m_age [2];
   int          m_own [2];
   int          m_rr  [2];
   logic [31:0] m_a [2], m_b [2], m_sum [2];
   logic        m_cout [2], m_sub [2];

   function automatic int model_grant(input int d);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr[d] + k) % N;
         if (valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic advance(input int d, input int lat);
      int g;
      logic [31:0] a, b;
      if (rst) begin
         m_act[d] = 1'b0;
         m_rr[d]  = 0;
      end else if (m_act[d]) begin
         if (m_age[d] > lat && rsp_rdy[m_own[d]]) m_act[d] = 1'b0;
         else m_age[d]++;
      end else begin
         g = model_grant(d);
         if (g >= 0) begin
            a = ra[32*g +: 32];
            b = rb[32*g +: 32];
            m_act[d] = 1'b1;
            m_age[d] = 1;
            m_own[d] = g;
            m_a[d]   = a;
            m_b[d]   = b;
            m_sub[d] = SUB_ON && sub[g];
            if (m_sub[d]) begin
               m_sum[d]  = a - b;
               m_cout[d] = (a >= b);
            end else begin
               {m_cout[d], m_sum[d]} = {1'b0, a} + {1'b0, b};
            end
            m_rr[d] = (g + 1) % N;
         end
      end
   endtask

   task automatic check_dut(input int d, input int lat, input logic [N-1:0] rdy, input logic [N-1:0] rv,
                            input logic [31:0] data, input logic cout, input logic [31:0] aa,
                            input logic [31:0] ab, input logic acin, input logic bsy);
      int g;
      logic [31:0] e_rdy, e_rv;
      g     = model_grant(d);
      e_rdy = (!m_act[d] && g >= 0) ? (32'd1 << g) : 32'd0;
      e_rv  = (m_act[d] && m_age[d] > lat) ? (32'd1 << m_own[d]) : 32'd0;
      chk("req_ready", d, 32'(rdy), e_rdy);
      chk("rsp_valid", d, 32'(rv), e_rv);
      chk("busy", d, 32'(bsy), 32'(m_act[d]));
      if (m_act[d]) begin
         chk("add_a", d, aa, m_a[d]);
         chk("add_b", d, ab, m_sub[d] ? ~m_b[d] : m_b[d]);
         chk("add_cin", d, 32'(acin), 32'(m_sub[d]));
      end
      if (e_rv != 0) begin
         chk("rsp_data", d, data, m_sum[d]);
         chk("rsp_cout", d, 32'(cout), 32'(m_cout[d]));
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_dut(0, 1, rdy0, rv0, data0, cout0, aa0, ab0, acin0, bsy0);
         check_dut(1, 3, rdy1, rv1, data1, cout1, aa1, ab1, acin1, bsy1);
      end
      advance(0, 1);
      advance(1, 3);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      ra[32*i +: 32] = a;
      rb[32*i +: 32] = b;
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while ((bsy0 || bsy1) && n < 60) begin
         tick;
         n++;
      end
      chk("idle_timeout", 0, 32'(bsy0 | bsy1), 32'd0);
   endtask

   task automatic wait_grant(input logic [N-1:0] exp, input string nm);
      int w;
      w = 0;
      #1;
      while (rdy0 == '0 && w < 20) begin
         tick;
         #1;
         w++;
      end
      chk(nm, 0, 32'(rdy0), 32'(exp));
   endtask

   logic [N-1:0] t3_exp [4];

   initial begin
      t3_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
      tick;
      tick;
      rst    = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_rsp_valid", 0, 32'(rv0), 32'd0);
      chk("rst_busy", 0, 32'(bsy0), 32'd0);
      chk("rst_data", 0, data0, 32'd0);
      chk("rst_cout", 0, 32'(cout0), 32'd0);
      chk("rst_add_a", 0, aa0, 32'd0);

      // 5 + 7, latency 2 on dut0 and 4 on dut1
      set_op(0, 32'd5, 32'd7);
      valid = 3'b001;
      #1;
      chk("t1_ready", 0, 32'(rdy0), 32'd1);
      tick;
      valid = '0;
      tick;
      chk("t1_valid", 0, 32'(rv0), 32'd1);
      chk("t1_data", 0, data0, 32'd12);
      chk("t1_cout", 0, 32'(cout0), 32'd0);
      tick;
      tick;
      chk("t6_lat3_valid", 1, 32'(rv1), 32'd1);
      chk("t6_lat3_data", 1, data1, 32'd12);
      wait_idle;

      // carry-out wrap
      set_op(1, 32'hFFFF_FFFF, 32'd1);
      valid = 3'b010;
      #1;
      chk("t2_ready", 0, 32'(rdy0), 32'd2);
      tick;
      valid = '0;
      tick;
      chk("t2_valid", 0, 32'(rv0), 32'd2);
      chk("t2_data", 0, data0, 32'd0);
      chk("t2_cout", 0, 32'(cout0), 32'd1);
      wait_idle;

      // all requesters from reset: grants rotate 0,1,2,0
      rst = 1'b1;
      tick;
      rst = 1'b0;
      set_op(0, 32'd100, 32'd1);
      set_op(1, 32'd200, 32'd2);
      set_op(2, 32'hFFFF_FFF0, 32'h20);
      valid = 3'b111;
      for (int n = 0; n < 4; n++) begin
         wait_grant(t3_exp[n], "t3_grant");
         tick;
      end
      valid = '0;
      wait_idle;

      // req0 held, req2 raised: req2 gets the next grant
      valid = 3'b001;
      wait_grant(3'b001, "t4_grant0");
      tick;
      valid = 3'b101;
      wait_grant(3'b100, "t4_grant2");
      tick;
      wait_grant(3'b001, "t4_grant0b");
      tick;
      valid = '0;
      wait_idle;

      // back-pressure in RESP; operand change after accept ignored
      set_op(0, 32'd10, 32'd20);
      rsp_rdy = 3'b110;
      valid   = 3'b001;
      #1;
      tick;
      valid = 3'b010;
      set_op(0, 32'd99, 32'd99);
      tick;
      for (int n = 0; n < 3; n++) begin
         chk("t5_valid", 0, 32'(rv0), 32'd1);
         chk("t5_data", 0, data0, 32'd30);
         chk("t5_ready", 0, 32'(rdy0), 32'd0);
         chk("t5_busy", 0, 32'(bsy0), 32'd1);
         if (n < 2) tick;
      end
      rsp_rdy = 3'b111;
      tick;
      chk("t5_idle", 0, 32'(bsy0), 32'd0);
      chk("t5_next_ready", 0, 32'(rdy0), 32'd2);
      valid = '0;
      wait_idle;

      // reset while BUSY drops the transaction
      set_op(0, 32'd1, 32'd2);
      valid = 3'b001;
      #1;
      tick;
      valid = '0;
      rst   = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      chk("t6_rsp_valid", 0, 32'(rv0), 32'd0);
      chk("t6_busy", 0, 32'(bsy0), 32'd0);
      chk("t6_data", 0, data0, 32'd0);
      chk("t6_cout", 0, 32'(cout0), 32'd0);
      chk("t6_add_a", 0, aa0, 32'd0);
      chk("t6_busy_lat3", 1, 32'(bsy1), 32'd0);
      chk("t6_rsp_valid_lat3", 1, 32'(rv1), 32'd0);
      repeat (6) tick;

`ifdef YSYX_23060062_ADDER_ARB_SUB_EN
      sub = 3'b001;
      set_op(0, 32'd3, 32'd5);
      valid = 3'b001;
      #1;
      tick;
      valid = '0;
      tick;
      chk("t7_sub_data", 0, data0, 32'hFFFF_FFFE);
      chk("t7_sub_cout", 0, 32'(cout0), 32'd0);
      wait_idle;
      set_op(0, 32'd5, 32'd3);
      valid = 3'b001;
      #1;
      tick;
      valid = '0;
      tick;
      chk("t7_sub_data2", 0, data0, 32'd2);
      chk("t7_sub_cout2", 0, 32'(cout0), 32'd1);
      wait_idle;
      sub = '0;
`endif

      tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

endmodule
